// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM port controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Requester index: 0 = CPU port, 1 = DMA/video port.
  typedef logic port_t;

  // Width of the strobe down-counter; covers strobe widths 1..15.
  localparam int unsigned STROBE_CNT_W = 4;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the port that was not granted last time.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic       grant_valid,
  output port_t      grant_idx
);

  // Pick the winner from the current request pair and the previous grant.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous 8-bit SRAM between two synchronous requesters,
// sequencing SETUP / STROBE / HOLD with every SRAM pin driven from a flop.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [7:0]            wdata0,
  input  logic [7:0]            wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [7:0]            rdata0,
  output logic [7:0]            rdata1,
  output logic                  busy,
  output logic                  sram_ce_n,
  output logic                  sram_ce2,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [7:0]            sram_data
);

  localparam logic [STROBE_CNT_W-1:0] CNT_LOAD = STROBE_CNT_W'(STROBE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [STROBE_CNT_W-1:0] cnt_q, cnt_d;
  port_t                   last_grant_q, last_grant_d;
  port_t                   winner_q, winner_d;
  logic                    we_lat_q, we_lat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              dout_q, dout_d;
  logic                    data_oe_q, data_oe_d;
  logic                    ce_n_q, ce_n_d;
  logic                    ce2_q, ce2_d;
  logic                    we_n_q, we_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;
  logic [7:0]              rdata0_q, rdata0_d;
  logic [7:0]              rdata1_q, rdata1_d;

  logic                    grant_valid;
  port_t                   grant_idx;

  sram_rr_arbiter u_arb (
    .req         ({req1, req0}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Pin values are computed one state ahead so each SRAM output is a flop
  // that already holds the right level for the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_lat_d     = we_lat_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    data_oe_d    = data_oe_q;
    ce_n_d       = ce_n_q;
    ce2_d        = ce2_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = SETUP;
          winner_d     = grant_idx;
          last_grant_d = grant_idx;
          we_lat_d     = grant_idx ? we1 : we0;
          addr_d       = grant_idx ? addr1 : addr0;
          dout_d       = grant_idx ? wdata1 : wdata0;
          data_oe_d    = grant_idx ? we1 : we0;
          ce_n_d       = 1'b0;
          ce2_d        = 1'b1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
        we_n_d  = ~we_lat_q;
        oe_n_d  = we_lat_q;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ack0_d  = ~winner_q;
          ack1_d  = winner_q;
          if (!we_lat_q) begin
            if (winner_q) rdata1_d = sram_data;
            else          rdata0_d = sram_data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        state_d   = IDLE;
        ce_n_d    = 1'b1;
        ce2_d     = 1'b0;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pin registers; reset forces strobes inactive without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_lat_q     <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      data_oe_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      ce2_q        <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_lat_q     <= we_lat_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      data_oe_q    <= data_oe_d;
      ce_n_q       <= ce_n_d;
      ce2_q        <= ce2_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign sram_data = data_oe_q ? dout_q : 'z;
  assign sram_ce_n = ce_n_q;
  assign sram_ce2  = ce2_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_addr = addr_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: two instances (strobe width 2 and 1),
// each attached to a behavioural asynchronous SRAM with a pulled-up bus.
module tb_sram_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Instance A: STROBE_CYCLES = 2
  logic        req0, req1, we0, we1;
  logic [16:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [7:0]  rdata0, rdata1;
  logic        sram_ce_n, sram_ce2, sram_we_n, sram_oe_n;
  logic [16:0] sram_addr;
  tri1  [7:0]  sram_data;
  logic [7:0]  mem0 [0:131071];

  // Instance B: STROBE_CYCLES = 1
  logic        b_req0, b_req1, b_we0, b_we1;
  logic [16:0] b_addr0, b_addr1;
  logic [7:0]  b_wdata0, b_wdata1;
  logic        b_ack0, b_ack1, b_busy;
  logic [7:0]  b_rdata0, b_rdata1;
  logic        b_ce_n, b_ce2, b_we_n, b_oe_n;
  logic [16:0] b_sram_addr;
  tri1  [7:0]  b_sram_data;
  logic [7:0]  mem1 [0:131071];

  sram_port_arbiter #(.ADDR_WIDTH(17), .STROBE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .sram_ce_n(sram_ce_n), .sram_ce2(sram_ce2), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_addr(sram_addr), .sram_data(sram_data)
  );

  sram_port_arbiter #(.ADDR_WIDTH(17), .STROBE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
    .sram_ce_n(b_ce_n), .sram_ce2(b_ce2), .sram_we_n(b_we_n),
    .sram_oe_n(b_oe_n), .sram_addr(b_sram_addr), .sram_data(b_sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: store while selected with WE low, drive while OE low.
  always @(posedge clk) begin
    if (!sram_ce_n && sram_ce2 && !sram_we_n) mem0[sram_addr] <= sram_data;
    if (!b_ce_n && b_ce2 && !b_we_n) mem1[b_sram_addr] <= b_sram_data;
  end
  assign sram_data   = (!sram_ce_n && sram_ce2 && !sram_oe_n && sram_we_n) ? mem0[sram_addr] : 'z;
  assign b_sram_data = (!b_ce_n && b_ce2 && !b_oe_n && b_we_n) ? mem1[b_sram_addr] : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare instance A's pins.
  task automatic step(input string tag, input logic e_ce_n, input logic e_ce2,
                      input logic e_we_n, input logic e_oe_n, input logic e_ack0,
                      input logic e_ack1, input logic e_busy, input logic [7:0] e_data);
    @(negedge clk);
    chk($sformatf("%s.ce_n", tag), sram_ce_n, e_ce_n);
    chk($sformatf("%s.ce2", tag), sram_ce2, e_ce2);
    chk($sformatf("%s.we_n", tag), sram_we_n, e_we_n);
    chk($sformatf("%s.oe_n", tag), sram_oe_n, e_oe_n);
    chk($sformatf("%s.ack0", tag), ack0, e_ack0);
    chk($sformatf("%s.ack1", tag), ack1, e_ack1);
    chk($sformatf("%s.busy", tag), busy, e_busy);
    chk($sformatf("%s.data", tag), sram_data, e_data);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_addr0 = '0; b_addr1 = '0;
    b_wdata0 = '0; b_wdata1 = '0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst.ce_n", sram_ce_n, 1'b1);
    chk("rst.ce2", sram_ce2, 1'b0);
    chk("rst.we_n", sram_we_n, 1'b1);
    chk("rst.oe_n", sram_oe_n, 1'b1);
    chk("rst.addr", sram_addr, 17'h00000);
    chk("rst.data", sram_data, 8'hFF);
    chk("rst.ack0", ack0, 1'b0);
    chk("rst.ack1", ack1, 1'b0);
    chk("rst.rdata0", rdata0, 8'h00);
    chk("rst.rdata1", rdata1, 8'h00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.b_busy", b_busy, 1'b0);
    rst_n = 1'b1;

    // Port 0 write A5 -> 0x12345
    req0 = 1; we0 = 1; addr0 = 17'h12345; wdata0 = 8'hA5;
    step("wr.c1", 0, 1, 1, 1, 0, 0, 1, 8'hA5);
    chk("wr.c1.addr", sram_addr, 17'h12345);
    step("wr.c2", 0, 1, 0, 1, 0, 0, 1, 8'hA5);
    step("wr.c3", 0, 1, 0, 1, 0, 0, 1, 8'hA5);
    step("wr.c4", 0, 1, 1, 1, 1, 0, 1, 8'hA5);
    chk("wr.c4.addr", sram_addr, 17'h12345);
    req0 = 0;
    step("wr.c5", 1, 0, 1, 1, 0, 0, 0, 8'hFF);
    chk("wr.mem", mem0[17'h12345], 8'hA5);

    // Port 1 read-back of 0x12345
    req1 = 1; we1 = 0; addr1 = 17'h12345;
    step("rd.c1", 0, 1, 1, 1, 0, 0, 1, 8'hFF);
    chk("rd.c1.addr", sram_addr, 17'h12345);
    step("rd.c2", 0, 1, 1, 0, 0, 0, 1, 8'hA5);
    step("rd.c3", 0, 1, 1, 0, 0, 0, 1, 8'hA5);
    step("rd.c4", 0, 1, 1, 1, 0, 1, 1, 8'hFF);
    chk("rd.c4.rdata1", rdata1, 8'hA5);
    req1 = 0;
    step("rd.c5", 1, 0, 1, 1, 0, 0, 0, 8'hFF);
    chk("rd.c5.rdata1", rdata1, 8'hA5);
    chk("rd.c5.rdata0", rdata0, 8'h00);

    // Tie: both ports write continuously, grants 0,1,0,1 every 5 cycles
    req0 = 1; we0 = 1; addr0 = 17'h00000; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 17'h1FFFF; wdata1 = 8'h22;
    for (int unsigned c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("tie.c%0d.ack0", c), ack0, (c == 4) || (c == 14));
      chk($sformatf("tie.c%0d.ack1", c), ack1, (c == 9) || (c == 19));
      if (c % 5 == 1) chk($sformatf("tie.c%0d.addr", c), sram_addr,
                          (c % 10 == 1) ? 17'h00000 : 17'h1FFFF);
      if (c == 19) begin req0 = 0; req1 = 0; end
    end
    chk("tie.busy", busy, 1'b0);
    chk("tie.mem0", mem0[17'h00000], 8'h11);
    chk("tie.mem1", mem0[17'h1FFFF], 8'h22);

    // Tie reads: port 0 first (port 1 granted last)
    req0 = 1; we0 = 0; addr0 = 17'h1FFFF;
    req1 = 1; we1 = 0; addr1 = 17'h00000;
    for (int unsigned c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("tierd.c%0d.ack0", c), ack0, c == 4);
      chk($sformatf("tierd.c%0d.ack1", c), ack1, c == 9);
      if (c == 4) begin chk("tierd.rdata0", rdata0, 8'h22); req0 = 0; end
      if (c == 9) begin chk("tierd.rdata1", rdata1, 8'h11); req1 = 0; end
    end
    chk("tierd.busy", busy, 1'b0);

    // Late request: req1 rises during port 0 STROBE
    req0 = 1; we0 = 1; addr0 = 17'h00020; wdata0 = 8'h77;
    for (int unsigned c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("late.c%0d.ack0", c), ack0, c == 4);
      chk($sformatf("late.c%0d.ack1", c), ack1, c == 9);
      if (c == 2) begin req1 = 1; we1 = 0; addr1 = 17'h00020; end
      if (c == 4) req0 = 0;
      if (c == 5) chk("late.c5.busy", busy, 1'b0);
      if (c == 6) chk("late.c6.ce_n", sram_ce_n, 1'b0);
      if (c == 9) begin chk("late.rdata1", rdata1, 8'h77); req1 = 0; end
    end

    // Reset during the second STROBE cycle of a write
    req0 = 1; we0 = 1; addr0 = 17'h00010; wdata0 = 8'h5A;
    step("mid.c1", 0, 1, 1, 1, 0, 0, 1, 8'h5A);
    step("mid.c2", 0, 1, 0, 1, 0, 0, 1, 8'h5A);
    step("mid.c3", 0, 1, 0, 1, 0, 0, 1, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.async.we_n", sram_we_n, 1'b1);
    chk("mid.async.ce_n", sram_ce_n, 1'b1);
    chk("mid.async.ce2", sram_ce2, 1'b0);
    chk("mid.async.oe_n", sram_oe_n, 1'b1);
    chk("mid.async.data", sram_data, 8'hFF);
    chk("mid.async.addr", sram_addr, 17'h00000);
    chk("mid.async.busy", busy, 1'b0);
    chk("mid.async.rdata0", rdata0, 8'h00);
    chk("mid.async.rdata1", rdata1, 8'h00);
    req0 = 0;
    for (int unsigned c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("mid.r%0d.ack0", c), ack0, 1'b0);
      chk($sformatf("mid.r%0d.we_n", c), sram_we_n, 1'b1);
    end
    rst_n = 1'b1;

    // First tie after reset goes to port 0
    req0 = 1; we0 = 0; addr0 = 17'h1FFFF;
    req1 = 1; we1 = 0; addr1 = 17'h00000;
    for (int unsigned c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) chk("post.c1.addr", sram_addr, 17'h1FFFF);
      chk($sformatf("post.c%0d.ack0", c), ack0, c == 4);
      chk($sformatf("post.c%0d.ack1", c), ack1, 1'b0);
      if (c == 4) begin chk("post.rdata0", rdata0, 8'h22); req0 = 0; req1 = 0; end
    end

    // Strobe width 1: write then read 3C at 0x0ABCD
    b_req0 = 1; b_we0 = 1; b_addr0 = 17'h0ABCD; b_wdata0 = 8'h3C;
    @(negedge clk);
    chk("s1w.c1.we_n", b_we_n, 1'b1);
    chk("s1w.c1.ce_n", b_ce_n, 1'b0);
    @(negedge clk);
    chk("s1w.c2.we_n", b_we_n, 1'b0);
    chk("s1w.c2.ack0", b_ack0, 1'b0);
    @(negedge clk);
    chk("s1w.c3.ack0", b_ack0, 1'b1);
    chk("s1w.c3.we_n", b_we_n, 1'b1);
    b_req0 = 0;
    @(negedge clk);
    chk("s1w.c4.busy", b_busy, 1'b0);
    chk("s1w.mem", mem1[17'h0ABCD], 8'h3C);
    b_req0 = 1; b_we0 = 0;
    @(negedge clk);
    chk("s1r.c1.oe_n", b_oe_n, 1'b1);
    @(negedge clk);
    chk("s1r.c2.oe_n", b_oe_n, 1'b0);
    chk("s1r.c2.data", b_sram_data, 8'h3C);
    @(negedge clk);
    chk("s1r.c3.ack0", b_ack0, 1'b1);
    chk("s1r.c3.rdata0", b_rdata0, 8'h3C);
    b_req0 = 0;
    @(negedge clk);
    chk("s1r.c4.busy", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
